// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared encodings, handshake levels and helpers for div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    // Helper width; callers zero-extend into it and truncate the result,
    // which yields the two's-complement negation at any operand width up to this.
    localparam int NEG_W = 128;

    function automatic logic [NEG_W-1:0] twos_negate(input logic [NEG_W-1:0] v);
        return ~v + NEG_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle restoring integer divider, one quotient bit per
//               clock, signed/unsigned, with divide-by-zero and annul support.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int                 c_cnt_w     = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    div_state_e           r_state;
    div_state_e           w_state_next;

    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_dividend;
    logic [WIDTH-1:0]     r_divisor;
    logic                 r_sign1;
    logic                 r_sign2;
    logic                 r_signed;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_ready;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic [WIDTH:0]       w_shifted;
    logic [WIDTH:0]       w_trial;
    logic                 w_qbit;
    logic [WIDTH:0]       w_rem_next;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_accept = (start_i == DivStart) && !annul_i;
    assign w_last   = (r_cnt == c_last_iter);

    always_comb begin
        w_abs1 = opdata1_i;
        w_abs2 = opdata2_i;
        if (signed_div_i && opdata1_i[WIDTH-1])
            w_abs1 = WIDTH'(twos_negate(NEG_W'(opdata1_i)));
        if (signed_div_i && opdata2_i[WIDTH-1])
            w_abs2 = WIDTH'(twos_negate(NEG_W'(opdata2_i)));
    end

    // Trial subtraction is WIDTH+1 bits wide; its MSB is the borrow/sign.
    always_comb begin
        w_shifted  = (r_rem << 1) | {{WIDTH{1'b0}}, r_dividend[WIDTH-1]};
        w_trial    = w_shifted - {1'b0, r_divisor};
        w_qbit     = ~w_trial[WIDTH];
        w_rem_next = w_qbit ? w_trial : w_shifted;
        w_quot     = {r_dividend[WIDTH-2:0], w_qbit};
        w_rem      = WIDTH'(w_rem_next);
        w_quot_fix = w_quot;
        w_rem_fix  = w_rem;
        if (r_signed && (r_sign1 ^ r_sign2))
            w_quot_fix = WIDTH'(twos_negate(NEG_W'(w_quot)));
        if (r_signed && r_sign1)
            w_rem_fix = WIDTH'(twos_negate(NEG_W'(w_rem)));
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= DivFree;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DivFree: begin
                if (w_accept)
                    w_state_next = (opdata2_i == '0) ? DivByZero : DivOn;
            end
            DivByZero: w_state_next = DivEnd;
            DivOn: begin
                if (annul_i)
                    w_state_next = DivFree;
                else if (w_last)
                    w_state_next = DivEnd;
            end
            DivEnd: begin
                if (start_i == DivStop)
                    w_state_next = DivFree;
            end
            default: w_state_next = DivFree;
        endcase
    end

    // The dividend register doubles as the quotient shift register: each
    // iteration consumes its MSB and shifts the new quotient bit into its LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_signed   <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                DivFree: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_dividend <= w_abs1;
                        r_divisor  <= w_abs2;
                        r_sign1    <= opdata1_i[WIDTH-1];
                        r_sign2    <= opdata2_i[WIDTH-1];
                        r_signed   <= signed_div_i;
                    end
                end
                DivByZero: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                end
                DivOn: begin
                    if (annul_i) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end else begin
                        r_rem      <= w_rem_next;
                        r_dividend <= {r_dividend[WIDTH-2:0], w_qbit};
                        r_cnt      <= r_cnt + c_cnt_one;
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quot_fix};
                            r_ready  <= 1'b1;
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end else begin
                        r_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = (r_state != DivFree);

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit at WIDTH=32 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        s32 = 1'b0, start32 = 1'b0, annul32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] res32;
    logic        ready32, busy32;

    logic        s8 = 1'b0, start8 = 1'b0, annul8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] res8;
    logic        ready8, busy8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .signed_div_i(s32), .opdata1_i(a32), .opdata2_i(b32),
        .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(ready32),
        .busy_o(busy32)
    );

    div_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .signed_div_i(s8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(ready8),
        .busy_o(busy8)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain truncating integer division on sign/zero-extended values.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input int w,
                         input bit sgn, output logic [63:0] q, output logic [63:0] r);
        longint sa, sb, lq, lr;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if (sgn) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
        end else begin
            sa = longint'(a & mask);
            sb = longint'(b & mask);
        end
        if (sb == 0) begin
            q = '0;
            r = '0;
        end else begin
            lq = sa / sb;
            lr = sa % sb;
            q  = 64'(lq) & mask;
            r  = 64'(lr) & mask;
        end
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         output logic [63:0] got);
        logic [63:0] q, r, exp;
        int k, lat;
        model({32'd0, a}, {32'd0, b}, 32, sgn, q, r);
        exp = {r[31:0], q[31:0]};
        lat = (b == 0) ? 2 : 32;
        @(negedge clk);
        a32 = a; b32 = b; s32 = sgn; start32 = 1'b1;
        @(posedge clk); #1;
        check("busy32_after_start", {busy32, ready32}, 2'b10);
        a32 = $urandom; b32 = $urandom; s32 = ~sgn;
        k = 0;
        while (!ready32 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency32", k, lat);
        check("result32", res32, exp);
        got = res32;
        @(negedge clk);
        annul32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("hold32", {busy32, ready32, res32}, {2'b11, exp});
        @(negedge clk);
        start32 = 1'b0; annul32 = 1'b0;
        @(posedge clk); #1;
        check("release32", {busy32, ready32, res32}, 66'd0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sgn,
                        output logic [15:0] got);
        logic [63:0] q, r;
        logic [15:0] exp;
        int k, lat;
        model({56'd0, a}, {56'd0, b}, 8, sgn, q, r);
        exp = {r[7:0], q[7:0]};
        lat = (b == 0) ? 2 : 8;
        @(negedge clk);
        a8 = a; b8 = b; s8 = sgn; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'($urandom); b8 = 8'($urandom);
        k = 0;
        while (!ready8 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency8", k, lat);
        check("result8", res8, exp);
        got = res8;
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk); #1;
        check("release8", {busy8, ready8, res8}, 18'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] g32;
        logic [15:0] g8;
        logic        seen;

        repeat (3) @(posedge clk);
        #1;
        check("reset32", {busy32, ready32, res32}, 66'd0);
        check("reset8", {busy8, ready8, res8}, 18'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run32(32'd100, 32'd7, 1'b0, g32);
        check("u100_7", g32, 64'h00000002_0000000E);
        run32(32'hFFFFFFF9, 32'd2, 1'b1, g32);
        check("s-7_2", g32, 64'hFFFFFFFF_FFFFFFFD);
        run32(32'hFFFFFFF9, 32'd2, 1'b0, g32);
        check("u_big_2", g32, 64'h00000001_7FFFFFFC);
        run32(32'd12345, 32'd0, 1'b0, g32);
        check("div0", g32, 64'd0);
        run32(32'h80000000, 32'hFFFFFFFF, 1'b1, g32);
        check("ovf", g32, 64'h00000000_80000000);

        // Annul mid-operation at iteration 10
        @(negedge clk);
        a32 = 32'd1000; b32 = 32'd3; s32 = 1'b0; start32 = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            seen = seen | ready32;
        end
        @(negedge clk);
        annul32 = 1'b1; start32 = 1'b0;
        @(posedge clk); #1;
        check("annul_mid", {seen, busy32, ready32, res32}, 67'd0);
        @(negedge clk);
        annul32 = 1'b0;
        run32(32'd9, 32'd3, 1'b0, g32);
        check("after_annul", g32, 64'h00000000_00000003);

        // Annul on the final iteration edge wins
        @(negedge clk);
        a32 = 32'd77; b32 = 32'd5; start32 = 1'b1;
        @(posedge clk);
        repeat (31) @(posedge clk);
        @(negedge clk);
        annul32 = 1'b1; start32 = 1'b0;
        @(posedge clk); #1;
        check("annul_last", {busy32, ready32, res32}, 66'd0);
        @(negedge clk);
        annul32 = 1'b0;

        // Start with annul in FREE is ignored
        @(negedge clk);
        start32 = 1'b1; annul32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("annul_free", {busy32, ready32}, 2'b00);
        @(negedge clk);
        start32 = 1'b0; annul32 = 1'b0;

        // Reset mid-operation
        @(negedge clk);
        a32 = 32'h80000000; b32 = 32'hFFFFFFFF; s32 = 1'b1; start32 = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start32 = 1'b0;
        @(posedge clk); #1;
        check("reset_mid", {busy32, ready32, res32}, 66'd0);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=8 directed
        run8(8'd255, 8'd16, 1'b0, g8);
        check("u255_16", g8, 16'h0F0F);
        run8(8'h80, 8'h03, 1'b1, g8);
        check("s80_3", g8, 16'hFED6);
        run8(8'h80, 8'hFF, 1'b1, g8);

        // Randomized against the reference model
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            int sel;
            ra  = $urandom;
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      rb = 32'd0;
            else if (sel < 4)  rb = $urandom_range(1, 255);
            else if (sel == 4) rb = 32'hFFFFFFFF - $urandom_range(0, 15);
            else               rb = $urandom;
            run32(ra, rb, 1'($urandom), g32);
        end
        for (int i = 0; i < 16; i++) begin
            run8(8'($urandom), 8'($urandom_range(0, 255)), 1'($urandom), g8);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
